// File: rtl/video_pkg.sv
// Shared timing defaults and coordinate type for the RGB LCD raster generator.
package video_pkg;

   localparam int COORD_W = 10;

   // 480x272 panel at a 9 MHz pixel clock
   localparam int H_RES   = 480;
   localparam int H_FP    = 2;
   localparam int H_SYNC  = 41;
   localparam int H_BP    = 2;
   localparam int V_RES   = 272;
   localparam int V_FP    = 2;
   localparam int V_SYNC  = 10;
   localparam int V_BP    = 2;

   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/video_signal_generator_if.sv
// Raster timing bundle from the generator to the pixel pipeline.
// The de signal exists only when VIDEO_DE_EN is defined.
interface video_signal_generator_if;
   import video_pkg::*;

   logic   hsync;
   logic   vsync;
   coord_t sx;
   coord_t sy;
`ifdef VIDEO_DE_EN
   logic   de;
`endif

   modport master (
      output hsync, vsync, sx, sy
`ifdef VIDEO_DE_EN
      , output de
`endif
   );

   modport slave (
      input hsync, vsync, sx, sy
`ifdef VIDEO_DE_EN
      , input de
`endif
   );

endinterface

// File: rtl/video_signal_generator_sync_counter.sv
// One raster axis: wrapping position counter with a registered active-low
// sync strobe decoded from the next count so it has zero skew against it.
module sync_counter
   import video_pkg::*;
#(
   parameter int ACTIVE = H_RES,
   parameter int FRONT  = H_FP,
   parameter int PULSE  = H_SYNC,
   parameter int BACK   = H_BP
) (
   input  logic   clk,
   input  logic   rstn,
   input  logic   en,
   output coord_t count,
   output logic   sync_n,
   output logic   wrap,
   output logic   active
);

   localparam int     TOTAL    = ACTIVE + FRONT + PULSE + BACK;
   localparam coord_t LAST     = coord_t'(TOTAL - 1);
   localparam coord_t ACT_END  = coord_t'(ACTIVE);
   localparam coord_t SYNC_BEG = coord_t'(ACTIVE + FRONT);
   localparam coord_t SYNC_END = coord_t'(ACTIVE + FRONT + PULSE);

   if (ACTIVE < 1 || FRONT < 1 || PULSE < 1 || BACK < 1) begin : g_bad_param
      $fatal(1, "sync_counter: every timing parameter must be >= 1");
   end
   if (TOTAL > (1 << COORD_W)) begin : g_bad_total
      $fatal(1, "sync_counter: total period exceeds the coordinate range");
   end

   coord_t count_q, count_d;
   logic   sync_n_q, sync_n_d;

   assign wrap = en && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (wrap)    count_d = '0;
      else if (en) count_d = count_q + coord_t'(1);
   end

   assign sync_n_d = !((count_d >= SYNC_BEG) && (count_d < SYNC_END));
   // next-cycle active flag, so whoever registers it stays aligned with count
   assign active   = (count_d < ACT_END);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q  <= '0;
         sync_n_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         sync_n_q <= sync_n_d;
      end
   end

   assign count  = count_q;
   assign sync_n = sync_n_q;

endmodule

// File: rtl/video_signal_generator.sv
// Free-running raster timing generator: sx/sy plus active-low hsync/vsync.
// Define VIDEO_DE_EN to add the registered data-enable output de.
module video_signal_generator
   import video_pkg::*;
#(
   parameter int HRes        = H_RES,
   parameter int VRes        = V_RES,
   parameter int HFrontPorch = H_FP,
   parameter int HSyncPulse  = H_SYNC,
   parameter int HBackPorch  = H_BP,
   parameter int VFrontPorch = V_FP,
   parameter int VSyncPulse  = V_SYNC,
   parameter int VBackPorch  = V_BP
) (
   input logic                      clk,
   input logic                      rstn,
   video_signal_generator_if.master vid
);

   logic h_wrap, v_wrap, h_act, v_act;

   sync_counter #(
      .ACTIVE (HRes),
      .FRONT  (HFrontPorch),
      .PULSE  (HSyncPulse),
      .BACK   (HBackPorch)
   ) u_h (
      .clk    (clk),
      .rstn   (rstn),
      .en     (1'b1),
      .count  (vid.sx),
      .sync_n (vid.hsync),
      .wrap   (h_wrap),
      .active (h_act)
   );

   // the line wrap is the only thing that advances the vertical axis
   sync_counter #(
      .ACTIVE (VRes),
      .FRONT  (VFrontPorch),
      .PULSE  (VSyncPulse),
      .BACK   (VBackPorch)
   ) u_v (
      .clk    (clk),
      .rstn   (rstn),
      .en     (h_wrap),
      .count  (vid.sy),
      .sync_n (vid.vsync),
      .wrap   (v_wrap),
      .active (v_act)
   );

`ifdef VIDEO_DE_EN
   logic de_q, de_d;

   assign de_d = h_act && v_act;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) de_q <= 1'b0;
      else       de_q <= de_d;
   end

   assign vid.de = de_q;

   logic unused_wrap;
   assign unused_wrap = v_wrap;
`else
   logic unused_sig;
   assign unused_sig = ^{v_wrap, h_act, v_act};
`endif

endmodule

// File: tb/tb_video_signal_generator.sv
// Directed bench: default 480x272 timing on dut0, a shrunken raster on dut1
// so whole frames fit in a short run.
module tb_video_signal_generator;
   import video_pkg::*;

   // small raster: HTotal = 8+2+3+2 = 15, VTotal = 5+1+2+1 = 9, frame 135
   localparam int S_HR = 8, S_HF = 2, S_HS = 3, S_HB = 2;
   localparam int S_VR = 5, S_VF = 1, S_VS = 2, S_VB = 1;
   localparam int HT1 = 15, VT1 = 9;
   localparam int N_RUN = 52800;   // sy=100, sx=300 on the default raster

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_tot = 0;
   int   n_bad = 0;

   video_signal_generator_if v0 ();
   video_signal_generator_if v1 ();

   video_signal_generator dut0 (
      .clk  (clk),
      .rstn (rstn),
      .vid  (v0)
   );

   video_signal_generator #(
      .HRes (S_HR), .HFrontPorch (S_HF), .HSyncPulse (S_HS), .HBackPorch (S_HB),
      .VRes (S_VR), .VFrontPorch (S_VF), .VSyncPulse (S_VS), .VBackPorch (S_VB)
   ) dut1 (
      .clk  (clk),
      .rstn (rstn),
      .vid  (v1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tot++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_sx0"}, int'(v0.sx), 0);
      chk({tag, "_sy0"}, int'(v0.sy), 0);
      chk({tag, "_hs0"}, int'(v0.hsync), 1);
      chk({tag, "_vs0"}, int'(v0.vsync), 1);
      chk({tag, "_sx1"}, int'(v1.sx), 0);
      chk({tag, "_sy1"}, int'(v1.sy), 0);
`ifdef VIDEO_DE_EN
      chk({tag, "_de0"}, int'(v0.de), 0);
`endif
   endtask

   // expected small-raster outputs n edges after reset release
   task automatic chk_small(input int n);
      int sx, sy;
      sx = n % HT1;
      sy = (n / HT1) % VT1;
      chk("s_sx", int'(v1.sx), sx);
      chk("s_sy", int'(v1.sy), sy);
      chk("s_hs", int'(v1.hsync), (sx >= 10 && sx < 13) ? 0 : 1);
      chk("s_vs", int'(v1.vsync), (sy >= 6 && sy < 8) ? 0 : 1);
`ifdef VIDEO_DE_EN
      chk("s_de", int'(v1.de), (sx < 8 && sy < 5) ? 1 : 0);
`endif
   endtask

   initial begin
      int   hs_fall0, hs_fall1, hs_rise1, vs_fall1, vs_rise1;
      logic p_hs0, p_hs1, p_vs1;
      hs_fall0 = -1; hs_fall1 = -1; vs_fall1 = -1;
      hs_rise1 = -1; vs_rise1 = -1;

      repeat (10) begin
         @(negedge clk);
         chk_rst("rst");
      end

      rstn  = 1'b1;
      p_hs0 = 1'b1; p_hs1 = 1'b1; p_vs1 = 1'b1;
      for (int n = 1; n <= N_RUN; n++) begin
         @(negedge clk);
         if (n <= 3 * HT1 * VT1) chk_small(n);

         case (n)
            1: begin
               chk("first_sx", int'(v0.sx), 1);
               chk("first_sy", int'(v0.sy), 0);
               chk("first_hs", int'(v0.hsync), 1);
               chk("first_vs", int'(v0.vsync), 1);
`ifdef VIDEO_DE_EN
               chk("first_de", int'(v0.de), 1);
            end
            479: chk("de_479", int'(v0.de), 1);
            480: begin
               chk("de_480", int'(v0.de), 0);
`endif
            end
            481: begin
               chk("sx_481", int'(v0.sx), 481);
               chk("hs_481", int'(v0.hsync), 1);
            end
            482: begin
               chk("sx_482", int'(v0.sx), 482);
               chk("hs_482", int'(v0.hsync), 0);
            end
            522: chk("hs_522", int'(v0.hsync), 0);
            523: chk("hs_523", int'(v0.hsync), 1);
            524: begin
               chk("sx_524", int'(v0.sx), 524);
               chk("sy_524", int'(v0.sy), 0);
            end
            525: begin
               chk("wrap_sx", int'(v0.sx), 0);
               chk("wrap_sy", int'(v0.sy), 1);
               chk("wrap_vs", int'(v0.vsync), 1);
            end
            N_RUN: begin
               chk("mid_sx", int'(v0.sx), 300);
               chk("mid_sy", int'(v0.sy), 100);
               chk("mid_vs", int'(v0.vsync), 1);
            end
            default: ;
         endcase

         // edge-to-edge timing, measured on the bench's own cycle count
         if (p_hs0 && !v0.hsync) begin
            if (hs_fall0 >= 0) chk("hs_period0", n - hs_fall0, 525);
            hs_fall0 = n;
         end
         if (p_hs1 && !v1.hsync) begin
            if (hs_fall1 >= 0) chk("hs_period1", n - hs_fall1, HT1);
            hs_fall1 = n;
         end
         if (!p_hs1 && v1.hsync && hs_fall1 >= 0) chk("hs_width1", n - hs_fall1, S_HS);
         if (p_vs1 && !v1.vsync) begin
            if (vs_fall1 >= 0) chk("vs_period1", n - vs_fall1, HT1 * VT1);
            else chk("vs_first_fall1", n, 6 * HT1);
            chk("vs_fall_sx1", int'(v1.sx), 0);
            chk("vs_fall_sy1", int'(v1.sy), 6);
            vs_fall1 = n;
         end
         if (!p_vs1 && v1.vsync && vs_fall1 >= 0) begin
            chk("vs_width1", n - vs_fall1, S_VS * HT1);
            chk("vs_rise_sy1", int'(v1.sy), 8);
         end
         p_hs0 = v0.hsync; p_hs1 = v1.hsync; p_vs1 = v1.vsync;
      end

      // asynchronous reset between edges, mid-frame
      #2 rstn = 1'b0;
      #1 chk_rst("arst");
      @(posedge clk);
      #1 chk_rst("arst_hold");
      @(negedge clk);
      rstn = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         chk_small(n);
         if (n == 1) begin
            chk("restart_sx", int'(v0.sx), 1);
            chk("restart_sy", int'(v0.sy), 0);
         end
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/video_signal_generator.md
# video_signal_generator

Free-running raster timing generator for the parallel RGB LCD path (default 480×272 at a 9 MHz pixel clock). It produces the horizontal and vertical sync strobes and the current pixel coordinates. It sits between the pixel-clock domain root and the framebuffer/pixel pipeline, which uses `sx`/`sy` to fetch pixel data.

## Interface
- `HRes`, 480: active pixels per line.
- `VRes`, 272: active lines per frame.
- `HFrontPorch`, 2: horizontal front porch, in pixels.
- `HSyncPulse`, 41: hsync pulse width, in pixels.
- `HBackPorch`, 2: horizontal back porch, in pixels.
- `VFrontPorch`, 2: vertical front porch, in lines.
- `VSyncPulse`, 10: vsync pulse width, in lines.
- `VBackPorch`, 2: vertical back porch, in lines.
- `clk` in 1: pixel clock. This is the only clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `sx` out 10: current horizontal position, 0..HTotal-1.
- `sy` out 10: current vertical position, 0..VTotal-1.
- `de` out 1: data enable. Present only with `VIDEO_DE_EN`.

## Operation
- Totals:
  - HTotal = HRes+HFrontPorch+HSyncPulse+HBackPorch (default 525).
  - VTotal = VRes+VFrontPorch+VSyncPulse+VBackPorch (default 286).
- Horizontal regions of `sx`, in order: active 0..HRes-1, front porch, sync, back porch.
- Vertical regions of `sy` follow the same order.
- `sx` increments by 1 every clock. At HTotal-1 it wraps to 0.
- `sy` increments only on the clock where `sx` wraps. At VTotal-1 it wraps to 0, on the same clock that `sx` wraps.
- `hsync` is 0 exactly when HRes+HFrontPorch ≤ sx < HRes+HFrontPorch+HSyncPulse (default sx 482..522). Otherwise 1.
- `vsync` is 0 exactly when VRes+VFrontPorch ≤ sy < VRes+VFrontPorch+VSyncPulse (default sy 274..283). Otherwise 1. `vsync` is independent of `sx`.
- All outputs are registers.
  - `hsync`/`vsync` are decoded from the next-state counter values, so they are cycle-aligned with the registered `sx`/`sy` and have zero skew against them.
- Elaboration-time checks: HTotal ≤ 1024 and VTotal ≤ 1024; every parameter ≥ 1. Violating either is a fatal elaboration error.
- Counters are unsigned 10-bit. Region comparisons are unsigned, against 10-bit constants.

## Timing
- Reset values while `rstn`=0: `sx`=0, `sy`=0, `hsync`=1, `vsync`=1, `de`=0 when enabled.
- Assertion of `rstn` takes effect immediately, with no clock needed, and also applies mid-line or mid-frame.
- The first rising edge after `rstn` deasserts gives `sx`=1 and `sy`=0.
- `sx`=0/`sy`=0 is the state at reset release, not a cycle produced by a clock.
- Line period is HTotal clocks. Frame period is HTotal×VTotal clocks (default 150150, about 59.94 Hz at 9 MHz).
- hsync falls on the cycle where `sx` becomes HRes+HFrontPorch and stays low for exactly HSyncPulse cycles.
- vsync falls on the cycle where `sy` becomes VRes+VFrontPorch, which coincides with `sx`=0. It stays low for VSyncPulse×HTotal cycles.
- There is no input handshake. The generator never stalls.

## Configuration
- `VIDEO_DE_EN` defined: adds port `de`.
  - `de`=1 exactly when sx<HRes and sy<VRes.
  - It is registered and aligned with `sx`/`sy`.
  - At reset release it is 0. It becomes 1 from the first clock edge, when `sx`=1.
- `VIDEO_DE_EN` undefined: the `de` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `video_pkg`:
  - default timing localparams for the 480×272 panel;
  - the coordinate width constant (10);
  - a typedef for the coordinate type.
- One natural sub-module, `sync_counter`, instantiated twice (horizontal and vertical).
  - Parameters: active, front porch, pulse, back porch.
  - Inputs: `clk`, `rstn`, `en`.
  - Outputs: `count`, `sync_n`, `wrap`, `active`.
  - The horizontal instance has `en` tied to 1. The vertical instance's `en` is the horizontal `wrap`.

## Test plan
- Reset: hold `rstn`=0 for 10 clocks → `sx`=0, `sy`=0, `hsync`=1, `vsync`=1 throughout.
- First line: 482nd edge after release → `sx`=482 and `hsync`=0. `hsync` stays 0 through `sx`=522. It is 1 at `sx`=523.
- Line wrap: `sx`=524 then `sx`=0 with `sy`=1. Measure the `hsync` falling-edge period = 525 clocks.
- Vertical: vsync falls when `sy`=274 and `sx`=0. It stays low for 5250 clocks and rises at `sy`=284, `sx`=0.
- Frame: `sy`=285/`sx`=524 then `sy`=0/`sx`=0. The `vsync` falling-edge period is 150150 clocks. Run 20 ms and check consistency.
- Async reset mid-frame: assert `rstn`=0 at `sy`=100, `sx`=300 between clock edges → outputs return to reset values before the next edge. Release → the sequence restarts from 0.
